// File: rtl/spi_pkg.sv
// Shared command encodings, frame geometry and FSM state encoding for the SPI master.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    TAIL,
    WAIT,
    RECV,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response bundle of the SPI master; 'master' is the host, 'slave' the SPI master block.
interface spi_master_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_cmd;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output req_valid, req_cmd, req_data,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_data,
    output req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/spi_shift_reg.sv
// 10-bit PISO frame register plus 8-bit SIPO receive register sharing one down-counter.
// Counter holds at zero; a load takes priority over a decrement in the same cycle.
module spi_shift_reg
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_val,
  input  logic               shift_en,
  input  logic               sample_en,
  input  logic               serial_in,
  input  logic               cnt_load,
  input  logic [3:0]         cnt_init,
  output logic               tx_bit,
  output logic [DATA_W-1:0]  rx_byte,
  output logic               cnt_zero
);

  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-1:0]  rx_q;
  logic [3:0]         cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load)
        tx_q <= load_val;
      else if (shift_en)
        tx_q <= {tx_q[FRAME_W-2:0], 1'b0};

      if (sample_en)
        rx_q <= {rx_q[DATA_W-2:0], serial_in};

      if (cnt_load)
        cnt_q <= cnt_init;
      else if ((shift_en || sample_en) && (cnt_q != 4'd0))
        cnt_q <= cnt_q - 4'd1;
    end
  end

  assign tx_bit   = tx_q[FRAME_W-1];
  assign rx_byte  = rx_q;
  assign cnt_zero = (cnt_q == 4'd0);

endmodule

// File: rtl/spi_master.sv
// SPI initiator: one {cmd,data} frame per accepted request; all outputs registered, one cycle behind the FSM.
// req_ready only in IDLE (no queuing); SPI_MASTER_SEQ_CHECK_EN drops read-data requests not preceded by a read-addr.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LAT  = 3,
  parameter int GAP_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_master_if.slave bus,
  input  logic        MISO,
  output logic        MOSI,
  output logic        SS_n
`ifdef SPI_MASTER_SEQ_CHECK_EN
  ,
  output logic        seq_err
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_INIT  = 4'(GAP_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [1:0]        cmd_q;
  logic              ready_q, busy_q, done, done_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              accept, reject;
  logic              sr_load, shift_en, sample_en, cnt_load, cnt_zero, tx_bit;
  logic [3:0]        cnt_init;
  logic [DATA_W-1:0] rx_byte;

  assign accept = bus.req_valid && ready_q;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic addr_ok_q, rej_q;

  assign reject = accept && (bus.req_cmd == CMD_RD_DATA) && !addr_ok_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_ok_q <= 1'b0;
      rej_q     <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      if (accept && (bus.req_cmd == CMD_RD_ADDR))
        addr_ok_q <= 1'b1;
      else if (accept && (bus.req_cmd == CMD_RD_DATA))
        addr_ok_q <= 1'b0;
      rej_q   <= reject;
      seq_err <= rej_q;
    end
  end
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    sr_load   = 1'b0;
    shift_en  = 1'b0;
    sample_en = 1'b0;
    cnt_load  = 1'b0;
    cnt_init  = 4'd0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (accept && !reject) begin
        state_d = START;
        sr_load = 1'b1;
      end
      START: begin
        state_d  = SHIFT;
        cnt_load = 1'b1;
        cnt_init = 4'(FRAME_W - 1);
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_zero) state_d = TAIL;
      end
      TAIL: begin
        state_d = (cmd_q == CMD_RD_DATA) ? WAIT : GAP;
        wcnt_d  = (cmd_q == CMD_RD_DATA) ? WAIT_INIT : GAP_INIT;
      end
      WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d  = RECV;
          cnt_load = 1'b1;
          cnt_init = 4'(DATA_W - 1);
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      RECV: begin
        sample_en = 1'b1;
        if (cnt_zero) begin
          state_d = GAP;
          wcnt_d  = GAP_INIT;
          done    = 1'b1;
        end
      end
      GAP: begin
        if (wcnt_q == 4'd0) state_d = IDLE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      cmd_q       <= 2'b00;
      SS_n        <= 1'b1;
      MOSI        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) cmd_q <= bus.req_cmd;
      SS_n        <= !(state_q inside {START, SHIFT, TAIL, WAIT, RECV});
      MOSI        <= (state_q == START || state_q == SHIFT) && tx_bit;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      // done_q delays the response so it lands with SS_n rising
      done_q      <= done;
      rsp_valid_q <= done_q;
      if (done_q) rsp_data_q <= rx_byte;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  spi_shift_reg u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sr_load),
    .load_val  ({bus.req_cmd, bus.req_data}),
    .shift_en  (shift_en),
    .sample_en (sample_en),
    .serial_in (MISO),
    .cnt_load  (cnt_load),
    .cnt_init  (cnt_init),
    .tx_bit    (tx_bit),
    .rx_byte   (rx_byte),
    .cnt_zero  (cnt_zero)
  );

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + RAM model on the serial pins.
module tb_spi_master;
  import spi_pkg::*;

  localparam int RD_LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic miso  = 1'b0;
  logic mosi, ss_n;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic seq_err;
`endif

  int total = 0;
  int bad   = 0;

  spi_master_if bus ();

  spi_master #(.RD_LAT(RD_LAT), .GAP_CYC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .MISO  (miso),
    .MOSI  (mosi),
    .SS_n  (ss_n)
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    .seq_err (seq_err)
`endif
  );

  always #5 clk = ~clk;

  // Slave model: pos is the cycle index within the SS_n-low window (cycle 1 = command-check bit).
  int         pos = 0;
  logic [9:0] rxf = '0;
  logic [7:0] s_addr = '0, s_raddr = '0, tx = '0;
  logic [7:0] ram [256] = '{default: 8'h00};

  always @(negedge clk) begin
    if (ss_n) pos <= 0;
    else      pos <= pos + 1;
    if (!ss_n && pos + 1 >= 2 && pos + 1 <= 11)
      rxf <= {rxf[8:0], mosi};
    if (!ss_n && pos + 1 == 12) begin
      case (rxf[9:8])
        2'b00:   s_addr       <= rxf[7:0];
        2'b01:   ram[s_addr]  <= rxf[7:0];
        2'b10:   s_raddr      <= rxf[7:0];
        default: tx           <= ram[s_raddr];
      endcase
    end
    if (!ss_n && pos + 1 >= 12 + RD_LAT && pos + 1 <= 19 + RD_LAT)
      miso <= tx[3'(18 + RD_LAT - pos)];
    else
      miso <= 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the accept edge (cycle 0).
  task automatic send(input logic [1:0] c, input logic [7:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = c;
    bus.req_data  = d;
    while (!bus.req_ready && n < 60) begin
      tick();
      n++;
    end
    chk("accept_seen", 16'(bus.req_ready), 16'h1);
    tick();
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic [7:0] exp);
    int n = 0;
    while (!bus.rsp_valid && n < 60) begin
      tick();
      n++;
    end
    chk("rsp_seen", 16'(bus.rsp_valid), 16'h1);
    chk("rsp_data", 16'(bus.rsp_data), 16'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [10:0] wa_pat;
    wa_pat = 11'b00010100101;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_data  = 8'h00;

    repeat (3) tick();
    chk("rst_pins", {11'h0, ss_n, mosi, bus.rsp_valid, bus.busy, bus.req_ready}, 16'b10000);
    chk("rst_rsp_data", 16'(bus.rsp_data), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 16'(bus.req_ready), 16'h1);
    chk("busy_after_rst", 16'(bus.busy), 16'h0);

    // Write addr 0xA5: MOSI cycles 1..11, SS_n low 1..12, ready back at 13
    send(CMD_WR_ADDR, 8'hA5, 1'b0);
    chk("wa_c0_ready", 16'(bus.req_ready), 16'h0);
    chk("wa_c0_busy", 16'(bus.busy), 16'h1);
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("wa_ss_c%0d", k), 16'(ss_n), 16'(k > 12));
      chk($sformatf("wa_mosi_c%0d", k), 16'(mosi), (k <= 11) ? 16'(wa_pat[11-k]) : 16'h0);
      chk($sformatf("wa_rspv_c%0d", k), 16'(bus.rsp_valid), 16'h0);
      chk($sformatf("wa_ready_c%0d", k), 16'(bus.req_ready), 16'(k == 13));
    end
    chk("wa_c13_busy", 16'(bus.busy), 16'h0);

    // Back-to-back: 01/FF then 10/12 with req_valid held
    send(CMD_WR_DATA, 8'hFF, 1'b1);
    bus.req_cmd  = CMD_RD_ADDR;
    bus.req_data = 8'h12;
    tick();
    chk("b2b_c1_mosi", 16'(mosi), 16'h0);
    tick();
    chk("b2b_c2_mosi", 16'(mosi), 16'h0);
    tick();
    chk("b2b_c3_mosi", 16'(mosi), 16'h1);
    repeat (9) tick();
    chk("b2b_c12_ss", 16'(ss_n), 16'h0);
    tick();
    chk("b2b_c13_ss", 16'(ss_n), 16'h1);
    chk("b2b_c13_ready", 16'(bus.req_ready), 16'h1);
    tick();
    chk("b2b_c14_ready", 16'(bus.req_ready), 16'h0);
    chk("b2b_c14_ss", 16'(ss_n), 16'h1);
    chk("b2b_c14_busy", 16'(bus.busy), 16'h1);
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_2nd_c1_ss", 16'(ss_n), 16'h0);
    chk("b2b_2nd_c1_mosi", 16'(mosi), 16'h1);

    // Read-data loopback 0x3C: rsp_valid at cycle 24 with SS_n rising
    send(CMD_WR_ADDR, 8'h20, 1'b0);
    send(CMD_WR_DATA, 8'h3C, 1'b0);
    send(CMD_RD_ADDR, 8'h20, 1'b0);
    send(CMD_RD_DATA, 8'h00, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("rd_rspv_c%0d", k), 16'(bus.rsp_valid), 16'(k == 24));
      if (k == 23) chk("rd_c23_ss", 16'(ss_n), 16'h0);
    end
    chk("rd_c24_ss", 16'(ss_n), 16'h1);
    chk("rd_c24_data", 16'(bus.rsp_data), 16'h3C);
    tick();
    chk("rd_c25_rspv", 16'(bus.rsp_valid), 16'h0);
    chk("rd_c25_hold", 16'(bus.rsp_data), 16'h3C);

    // Read back the 0xFF written to 0xA5 by the back-to-back pair
    send(CMD_RD_ADDR, 8'hA5, 1'b0);
    send(CMD_RD_DATA, 8'h00, 1'b0);
    wait_rsp(8'hFF);

    // Reset mid-frame at cycle 6 of a write
    send(CMD_WR_ADDR, 8'h77, 1'b0);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_pins", {12'h0, ss_n, bus.busy, mosi, bus.rsp_valid}, 16'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", 16'(bus.req_ready), 16'h1);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    // Read-data with no prior read-addr is swallowed
    send(CMD_RD_DATA, 8'h00, 1'b0);
    chk("seq_c0_err", 16'(seq_err), 16'h0);
    chk("seq_c0_ready", 16'(bus.req_ready), 16'h1);
    tick();
    chk("seq_c1_err", 16'(seq_err), 16'h1);
    chk("seq_c1_ss", 16'(ss_n), 16'h1);
    tick();
    chk("seq_c2_err", 16'(seq_err), 16'h0);
    chk("seq_c2_ss", 16'(ss_n), 16'h1);
`endif

    // Full system: write 0x5A to 0x10, read it back
    send(CMD_WR_ADDR, 8'h10, 1'b0);
    send(CMD_WR_DATA, 8'h5A, 1'b0);
    send(CMD_RD_ADDR, 8'h10, 1'b0);
    send(CMD_RD_DATA, 8'h00, 1'b0);
    wait_rsp(8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
